sc_register_bank_p: RTL and testbench
=====================================

Name: sc_register_bank_p

Overview:
Parametrised register bank for the single-cycle core, the next generation of the fixed 8x32 bank. It holds the general-purpose register array, PC and branch-flag register. Added over the previous bank: configurable width/depth, optional hardwired-zero R0, write-to-read bypass, PC increment/load mode, and a debug read port. It sits between decode (register selects) and writeback (WB data, next PC, flags).

Parameters:
DATA_W, 32, width of every register and of PC
ADDR_W, 3, register select width; depth = 2**ADDR_W
FLAG_W, 4, branch flag register width (N,Z,C,V order, MSB first)
PC_RESET, 0, PC value on reset
PC_STEP, 4, PC increment when not loading
ZERO_R0, 0, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to read ports

Ports:
Clk  in  1  core clock, rising-edge active
Reset  in  1  asynchronous, active-high reset
Clk_Enable  in  1  global advance enable; 0 freezes all state
wEnable  in  1  register write enable
DestReg  in  ADDR_W  write select
OpReg1  in  ADDR_W  read select A
OpReg2  in  ADDR_W  read select B
DbgSel  in  ADDR_W  debug read select
WBDataIN  in  DATA_W  writeback data
PCLoad  in  1  1 = load PC_IN, 0 = increment by PC_STEP
PC_IN  in  DATA_W  next PC for load
BRFlags  in  FLAG_W  new flag values
SetFlags  in  1  flag update enable
OutA  out  DATA_W  read data A
OutB  out  DATA_W  read data B
DbgOut  out  DATA_W  debug read data (never bypassed)
PCOut  out  DATA_W  current PC
FlagsOut  out  FLAG_W  current flags

Behaviour:
- Reset (async, immediate, any cycle): all registers 0, PC = PC_RESET, flags 0. While Reset is high, bypass is suppressed, so OutA/OutB/DbgOut = 0, PCOut = PC_RESET, FlagsOut = 0. Deassertion takes effect at the next rising Clk.
- Write qualifier wq = Clk_Enable & wEnable & ~Reset & ~(ZERO_R0 & DestReg==0). On rising Clk with wq: reg[DestReg] <= WBDataIN. Latency: visible on the array read one edge later.
- Reads are combinational from the array. OutA = (BYPASS & wq & DestReg==OpReg1) ? WBDataIN : reg[OpReg1]; OutB likewise with OpReg2. Both ports may select the same register.
- ZERO_R0=1: any read of index 0 returns 0, including bypass and DbgOut.
- PC: on rising Clk with Clk_Enable: PCLoad ? PC_IN : PC + PC_STEP, modulo 2**DATA_W (wrap from all-ones-minus-3 to 0 for step 4; no overflow flag). Clk_Enable=0 holds PC.
- Flags: on rising Clk with Clk_Enable & SetFlags: flags <= BRFlags; otherwise hold. Flags are not bypassed; FlagsOut shows the registered value.
- Simultaneous events: write, PC update and flag update all occur on the same edge, independently. Clk_Enable=0 blocks all three, and bypass is inactive.
- Out-of-range selects cannot occur (depth = 2**ADDR_W). Inputs that are X while Clk_Enable=0 must not corrupt state.

Decomposition:
- Shared package sc_core_pkg: DATA_W/ADDR_W/FLAG_W defaults, PC_STEP, flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module: sc_regfile_array (storage, write decode, ZERO_R0 masking, three async read ports). The top adds bypass muxes, PC and flag registers.

Test Plan:
- Reset mid-run: write 'hFFFF to R1, then pulse Reset between edges -> OutA(OpReg1=1)=0, PCOut=PC_RESET, FlagsOut=0 immediately, without waiting for an edge.
- Fill R1..R7 with 'hFFFF,'hFFFF,'hEEEE,'hDDDD,'hCCCC,'hBBBB,'hAAAA. Then read OpReg1=5, OpReg2=3 -> OutA='hCCCC, OutB='hEEEE. DbgSel=7 -> 'hAAAA.
- Bypass: R2='h1234, same cycle wEnable=1, DestReg=2, WBDataIN='h5678, OpReg1=2 -> OutA='h5678 before the edge and DbgOut(2)='h1234. With BYPASS=0, OutA='h1234. With Clk_Enable=0, OutA='h1234 and there is no write.
- ZERO_R0=1: write 'hBEEF to R0 -> OutA(0)=0 before and after the edge. With ZERO_R0=0, OutA(0)='hBEEF after the edge.
- PC: from reset (0), 3 edges with PCLoad=0 -> 'hC. PCLoad=1, PC_IN='hFFFFFFFC -> 'hFFFFFFFC, then next increment -> 0 (wrap). Clk_Enable=0 for 2 edges -> PC unchanged.
- Flags: SetFlags=1, BRFlags='b1010 -> FlagsOut='b1010 after the edge. SetFlags=0, BRFlags='b0101 -> FlagsOut stays 'b1010.

Source files
------------

// File: rtl/sc_core_pkg.sv
// Shared defaults for the single-cycle core: datapath widths, PC step and
// branch-flag bit positions (N,Z,C,V, MSB first).
package sc_core_pkg;

    localparam int unsigned SC_DATA_W  = 32;
    localparam int unsigned SC_ADDR_W  = 3;
    localparam int unsigned SC_FLAG_W  = 4;
    localparam int unsigned SC_PC_STEP = 4;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/sc_regfile_array.sv
// General-purpose register storage: one write port, three combinational read
// ports, with optional hardwired-zero register 0.
module sc_regfile_array
    import sc_core_pkg::*;
#(
    parameter int unsigned DATA_W  = SC_DATA_W,
    parameter int unsigned ADDR_W  = SC_ADDR_W,
    parameter bit          ZERO_R0 = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    input  logic [ADDR_W-1:0] raddr_b_i,
    input  logic [ADDR_W-1:0] raddr_d_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] rdata_d_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en;

    assign wr_en = we_i && !(ZERO_R0 && (waddr_i == '0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Register 0 is masked on read as well, so it stays zero even if the
    // storage cell were ever loaded.
    assign rdata_a_o = (ZERO_R0 && (raddr_a_i == '0)) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = (ZERO_R0 && (raddr_b_i == '0)) ? '0 : regs_q[raddr_b_i];
    assign rdata_d_o = (ZERO_R0 && (raddr_d_i == '0)) ? '0 : regs_q[raddr_d_i];

endmodule

// File: rtl/sc_register_bank_p.sv
// Parametrised register bank: GPR array with write-to-read bypass, PC with
// increment/load, and branch-flag register, all gated by Clk_Enable.
module sc_register_bank_p
    import sc_core_pkg::*;
#(
    parameter int unsigned     DATA_W   = SC_DATA_W,
    parameter int unsigned     ADDR_W   = SC_ADDR_W,
    parameter int unsigned     FLAG_W   = SC_FLAG_W,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int unsigned     PC_STEP  = SC_PC_STEP,
    parameter bit              ZERO_R0  = 1'b0,
    parameter bit              BYPASS   = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clk_Enable,
    input  logic              wEnable,
    input  logic [ADDR_W-1:0] DestReg,
    input  logic [ADDR_W-1:0] OpReg1,
    input  logic [ADDR_W-1:0] OpReg2,
    input  logic [ADDR_W-1:0] DbgSel,
    input  logic [DATA_W-1:0] WBDataIN,
    input  logic              PCLoad,
    input  logic [DATA_W-1:0] PC_IN,
    input  logic [FLAG_W-1:0] BRFlags,
    input  logic              SetFlags,
    output logic [DATA_W-1:0] OutA,
    output logic [DATA_W-1:0] OutB,
    output logic [DATA_W-1:0] DbgOut,
    output logic [DATA_W-1:0] PCOut,
    output logic [FLAG_W-1:0] FlagsOut
);

    logic              wq;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] pc_d;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;

    assign wq = Clk_Enable && wEnable && !Reset && !(ZERO_R0 && (DestReg == '0));

    sc_regfile_array #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_R0 (ZERO_R0)
    ) u_array (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .we_i      (wq),
        .waddr_i   (DestReg),
        .wdata_i   (WBDataIN),
        .raddr_a_i (OpReg1),
        .raddr_b_i (OpReg2),
        .raddr_d_i (DbgSel),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b),
        .rdata_d_o (DbgOut)
    );

    // wq already excludes a zeroed R0, so bypass can never leak data onto index 0.
    always_comb begin
        OutA = rd_a;
        OutB = rd_b;
        if (BYPASS && wq && (DestReg == OpReg1)) OutA = WBDataIN;
        if (BYPASS && wq && (DestReg == OpReg2)) OutB = WBDataIN;
    end

    always_comb begin
        pc_d    = pc_q;
        flags_d = flags_q;
        if (Clk_Enable) begin
            pc_d = PCLoad ? PC_IN : pc_q + DATA_W'(PC_STEP);
            if (SetFlags) flags_d = BRFlags;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q    <= PC_RESET;
            flags_q <= '0;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    assign PCOut    = pc_q;
    assign FlagsOut = flags_q;

endmodule

// File: tb/tb_sc_register_bank_p.sv
// Self-checking bench: three bank variants (default, zero-R0 with offset PC
// reset, no-bypass) against a behavioural array/PC/flags model.
module tb_sc_register_bank_p;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Clk_Enable;
    logic        wEnable;
    logic [2:0]  DestReg, OpReg1, OpReg2, DbgSel;
    logic [31:0] WBDataIN;
    logic        PCLoad;
    logic [31:0] PC_IN;
    logic [3:0]  BRFlags;
    logic        SetFlags;

    logic [31:0] a0, b0, d0, p0;  logic [3:0] f0;
    logic [31:0] a1, b1, d1, p1;  logic [3:0] f1;
    logic [31:0] a2, b2, d2, p2;  logic [3:0] f2;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [31:0] PCR_Z = 32'h100;

    always #5 Clk = ~Clk;

    sc_register_bank_p dut (
        .Clk(Clk), .Reset(Reset), .Clk_Enable(Clk_Enable), .wEnable(wEnable),
        .DestReg(DestReg), .OpReg1(OpReg1), .OpReg2(OpReg2), .DbgSel(DbgSel),
        .WBDataIN(WBDataIN), .PCLoad(PCLoad), .PC_IN(PC_IN), .BRFlags(BRFlags),
        .SetFlags(SetFlags), .OutA(a0), .OutB(b0), .DbgOut(d0), .PCOut(p0), .FlagsOut(f0)
    );

    sc_register_bank_p #(.PC_RESET(PCR_Z), .ZERO_R0(1'b1)) dut_z (
        .Clk(Clk), .Reset(Reset), .Clk_Enable(Clk_Enable), .wEnable(wEnable),
        .DestReg(DestReg), .OpReg1(OpReg1), .OpReg2(OpReg2), .DbgSel(DbgSel),
        .WBDataIN(WBDataIN), .PCLoad(PCLoad), .PC_IN(PC_IN), .BRFlags(BRFlags),
        .SetFlags(SetFlags), .OutA(a1), .OutB(b1), .DbgOut(d1), .PCOut(p1), .FlagsOut(f1)
    );

    sc_register_bank_p #(.BYPASS(1'b0)) dut_nb (
        .Clk(Clk), .Reset(Reset), .Clk_Enable(Clk_Enable), .wEnable(wEnable),
        .DestReg(DestReg), .OpReg1(OpReg1), .OpReg2(OpReg2), .DbgSel(DbgSel),
        .WBDataIN(WBDataIN), .PCLoad(PCLoad), .PC_IN(PC_IN), .BRFlags(BRFlags),
        .SetFlags(SetFlags), .OutA(a2), .OutB(b2), .DbgOut(d2), .PCOut(p2), .FlagsOut(f2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one array (R0 masking applied at read time for the
    // zero-R0 variant), two PCs (different reset values), shared flags.
    logic [31:0] m_reg [8];
    logic [31:0] m_pc, m_pcz;
    logic [3:0]  m_flags;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
            m_pc    = 32'h0;
            m_pcz   = PCR_Z;
            m_flags = 4'h0;
        end else if (Clk_Enable === 1'b1) begin
            if (wEnable === 1'b1) m_reg[DestReg] = WBDataIN;
            if (PCLoad === 1'b1) begin
                m_pc  = PC_IN;
                m_pcz = PC_IN;
            end else begin
                m_pc  = m_pc + 32'd4;
                m_pcz = m_pcz + 32'd4;
            end
            if (SetFlags === 1'b1) m_flags = BRFlags;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] sel, input bit byp, input bit zr0);
        bit wr;
        wr = (Clk_Enable === 1'b1) && (wEnable === 1'b1) && (Reset === 1'b0);
        if (zr0 && sel == 3'd0) return 32'h0;
        if (byp && wr && DestReg == sel) return WBDataIN;
        return m_reg[sel];
    endfunction

    always @(negedge Clk) begin
        chk("outa_main", a0, exp_rd(OpReg1, 1'b1, 1'b0));
        chk("outb_main", b0, exp_rd(OpReg2, 1'b1, 1'b0));
        chk("dbg_main",  d0, exp_rd(DbgSel, 1'b0, 1'b0));
        chk("pc_main",   p0, m_pc);
        chk("flags_main", {28'h0, f0}, {28'h0, m_flags});
        chk("outa_z",    a1, exp_rd(OpReg1, 1'b1, 1'b1));
        chk("outb_z",    b1, exp_rd(OpReg2, 1'b1, 1'b1));
        chk("dbg_z",     d1, exp_rd(DbgSel, 1'b0, 1'b1));
        chk("pc_z",      p1, m_pcz);
        chk("outa_nb",   a2, exp_rd(OpReg1, 1'b0, 1'b0));
        chk("outb_nb",   b2, exp_rd(OpReg2, 1'b0, 1'b0));
        chk("flags_nb",  {28'h0, f2}, {28'h0, m_flags});
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    logic [31:0] fillv [8];

    initial begin
        Reset = 1'b1; Clk_Enable = 1'b0; wEnable = 1'b0;
        DestReg = '0; OpReg1 = '0; OpReg2 = '0; DbgSel = '0;
        WBDataIN = '0; PCLoad = 1'b0; PC_IN = '0; BRFlags = '0; SetFlags = 1'b0;
        #1;
        chk("rst_pc", p0, 32'h0);
        chk("rst_pc_z", p1, 32'h100);
        step(); step();
        Reset = 1'b0;

        // PC increment, load, wrap, hold
        Clk_Enable = 1'b1;
        repeat (3) step();
        chk("pc_inc3", p0, 32'hC);
        PCLoad = 1'b1; PC_IN = 32'hFFFF_FFFC;
        step();
        chk("pc_load", p0, 32'hFFFF_FFFC);
        PCLoad = 1'b0;
        step();
        chk("pc_wrap", p0, 32'h0);
        Clk_Enable = 1'b0;
        repeat (2) step();
        chk("pc_hold", p0, 32'h0);

        // Fill R1..R7 and read back
        fillv[1] = 32'hFFFF; fillv[2] = 32'hFFFF; fillv[3] = 32'hEEEE; fillv[4] = 32'hDDDD;
        fillv[5] = 32'hCCCC; fillv[6] = 32'hBBBB; fillv[7] = 32'hAAAA;
        Clk_Enable = 1'b1; wEnable = 1'b1;
        for (int i = 1; i < 8; i++) begin
            DestReg = 3'(i); WBDataIN = fillv[i];
            step();
        end
        wEnable = 1'b0; OpReg1 = 3'd5; OpReg2 = 3'd3; DbgSel = 3'd7;
        #1;
        chk("fill_a5", a0, 32'hCCCC);
        chk("fill_b3", b0, 32'hEEEE);
        chk("fill_dbg7", d0, 32'hAAAA);

        // Flags set and hold
        SetFlags = 1'b1; BRFlags = 4'b1010;
        step();
        chk("flags_set", {28'h0, f0}, 32'hA);
        SetFlags = 1'b0; BRFlags = 4'b0101;
        step();
        chk("flags_hold", {28'h0, f0}, 32'hA);

        // Bypass
        wEnable = 1'b1; DestReg = 3'd2; WBDataIN = 32'h1234;
        step();
        WBDataIN = 32'h5678; OpReg1 = 3'd2; DbgSel = 3'd2;
        #1;
        chk("byp_a", a0, 32'h5678);
        chk("byp_dbg", d0, 32'h1234);
        chk("byp_nb_a", a2, 32'h1234);
        Clk_Enable = 1'b0;
        #1;
        chk("byp_ce0_a", a0, 32'h1234);
        step();
        Clk_Enable = 1'b1; wEnable = 1'b0;
        #1;
        chk("ce0_nowrite", a0, 32'h1234);

        // Zero R0
        wEnable = 1'b1; DestReg = 3'd0; WBDataIN = 32'hBEEF; OpReg1 = 3'd0;
        #1;
        chk("z_r0_pre", a1, 32'h0);
        step();
        wEnable = 1'b0;
        #1;
        chk("z_r0_post", a1, 32'h0);
        chk("r0_post", a0, 32'hBEEF);

        // Reset mid-cycle
        wEnable = 1'b1; DestReg = 3'd1; WBDataIN = 32'hFFFF;
        step();
        wEnable = 1'b0; OpReg1 = 3'd1;
        #1;
        chk("r1_before_rst", a0, 32'hFFFF);
        Reset = 1'b1;
        #1;
        chk("rst_a", a0, 32'h0);
        chk("rst_pc_mid", p0, 32'h0);
        chk("rst_pcz_mid", p1, 32'h100);
        chk("rst_flags", {28'h0, f0}, 32'h0);
        step();
        Reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            Clk_Enable = ($urandom_range(0, 7) != 0);
            Reset      = ($urandom_range(0, 99) == 0);
            OpReg1 = 3'($urandom); OpReg2 = 3'($urandom); DbgSel = 3'($urandom);
            if (!Clk_Enable && $urandom_range(0, 1) == 1) begin
                wEnable = 1'bx; DestReg = 'x; WBDataIN = 'x;
                PCLoad = 1'bx; PC_IN = 'x; BRFlags = 'x; SetFlags = 1'bx;
            end else begin
                wEnable  = $urandom_range(0, 1) == 1;
                DestReg  = 3'($urandom);
                WBDataIN = $urandom;
                PCLoad   = ($urandom_range(0, 3) == 0);
                PC_IN    = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : $urandom;
                BRFlags  = 4'($urandom);
                SetFlags = $urandom_range(0, 1) == 1;
            end
            step();
        end
        Reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
